// File: rtl/terminal_cell_bank.sv
// terminal_cell_bank
//   Registered multi-clause terminal cell. On start_i it snapshots the
//   terminal signals of NUM_C clause rows, resolves conflict first and,
//   when there is none, streams the implying clauses lowest index first
//   over a valid/ready handshake. It ends each round with a one-cycle
//   done_o pulse.
//
// Optional build macro: TERMINAL_CELL_BANK_STATS_EN
//   When defined, saturating 16-bit implication and conflict counters are
//   built. When undefined, both stat ports are tied to 0.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start_i              begin a round (only accepted in IDLE)
//   csat_i .. cmax_lvl_i per-clause terminal signals from the clause array
//   csat_drv_o           registered copy of the snapshot csat
//   imp_valid_o/ready_i  implication handshake; imp_cid_o / imp_lvl_o payload
//   conflict_o           conflict level, held until return to IDLE
//   conflict_cid_o       lowest conflicting clause
//   conflict_lvl_o       max cmax_lvl over the conflicting clauses
//   done_o, all_sat_o    round-complete pulse and all-satisfied flag
//   busy_o               high outside IDLE
//   stat_imp_cnt_o       implication handshakes (optional)
//   stat_conf_cnt_o      conflict rounds (optional)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start_i; the snapshot loads on start_i
// S_CAPTURE | derive conf/imp vectors from the snapshot, load the mask
// S_ARB     | report conflict, or drain the implication mask
// S_DONE    | done_o pulse; conflict fields still held
module terminal_cell_bank #(
  parameter int NUM_C       = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CID   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [NUM_C-1:0]             csat_i,
  input  logic [2*NUM_C-1:0]           freelitcnt_i,
  input  logic [WIDTH_C_LEN*NUM_C-1:0] clause_len_i,
  input  logic [NUM_C-1:0]             conflict_c_i,
  input  logic [NUM_C-1:0]             all_lit_false_i,
  input  logic [WIDTH_LVL*NUM_C-1:0]   cmax_lvl_i,
  output logic [NUM_C-1:0]             csat_drv_o,
  output logic                         imp_valid_o,
  input  logic                         imp_ready_i,
  output logic [WIDTH_CID-1:0]         imp_cid_o,
  output logic [WIDTH_LVL-1:0]         imp_lvl_o,
  output logic                         conflict_o,
  output logic [WIDTH_CID-1:0]         conflict_cid_o,
  output logic [WIDTH_LVL-1:0]         conflict_lvl_o,
  output logic                         done_o,
  output logic                         all_sat_o,
  output logic                         busy_o,
  output logic [15:0]                  stat_imp_cnt_o,
  output logic [15:0]                  stat_conf_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_ARB     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // snapshot registers
  logic [NUM_C-1:0]             csat_q, cc_q, alf_q;
  logic [2*NUM_C-1:0]           flc_q;
  logic [WIDTH_C_LEN*NUM_C-1:0] len_q;
  logic [WIDTH_LVL*NUM_C-1:0]   lvl_q;

  logic [NUM_C-1:0]     mask_q, mask_d;
  logic [NUM_C-1:0]     csat_drv_q, csat_drv_d;
  logic                 imp_valid_q, imp_valid_d;
  logic [WIDTH_CID-1:0] imp_cid_q, imp_cid_d;
  logic [WIDTH_LVL-1:0] imp_lvl_q, imp_lvl_d;
  logic                 conflict_q, conflict_d;
  logic [WIDTH_CID-1:0] conf_cid_q, conf_cid_d;
  logic [WIDTH_LVL-1:0] conf_lvl_q, conf_lvl_d;
  logic                 done_q, done_d;
  logic                 all_sat_q, all_sat_d;

  // per-clause terminal evaluation on the snapshot
  logic [NUM_C-1:0] len_nz, conf_vec, imp_vec;
  logic             all_sat_vec;

  always_comb begin
    len_nz      = '0;
    conf_vec    = '0;
    imp_vec     = '0;
    all_sat_vec = 1'b1;
    for (int k = 0; k < NUM_C; k++) begin
      len_nz[k]   = (len_q[k*WIDTH_C_LEN +: WIDTH_C_LEN] != '0);
      conf_vec[k] = cc_q[k] | (alf_q[k] & len_nz[k]);
      imp_vec[k]  = (flc_q[2*k +: 2] == 2'b01) & ~csat_q[k] & len_nz[k];
      all_sat_vec = all_sat_vec & (csat_q[k] | ~len_nz[k]);
    end
  end

  // conflict resolution: lowest index, unsigned max level
  logic [WIDTH_CID-1:0] conf_cid;
  logic [WIDTH_LVL-1:0] conf_lvl;

  always_comb begin
    conf_cid = '0;
    conf_lvl = '0;
    for (int k = NUM_C - 1; k >= 0; k--) begin
      if (conf_vec[k]) conf_cid = WIDTH_CID'(k);
    end
    for (int k = 0; k < NUM_C; k++) begin
      if (conf_vec[k] && (lvl_q[k*WIDTH_LVL +: WIDTH_LVL] > conf_lvl))
        conf_lvl = lvl_q[k*WIDTH_LVL +: WIDTH_LVL];
    end
  end

  // A handshake retires the lowest mask bit, which is always the one on
  // imp_cid_o. The picker then looks at what remains so the next
  // implication is registered for the following cycle.
  logic                 hs;
  logic [NUM_C-1:0]     mask_low, mask_nxt, pick_src;
  logic [WIDTH_CID-1:0] pick_cid;
  logic [WIDTH_LVL-1:0] pick_lvl;

  assign hs       = (state_q == S_ARB) & imp_valid_q & imp_ready_i;
  assign mask_low = mask_q & (~mask_q + NUM_C'(1));
  assign mask_nxt = hs ? (mask_q & ~mask_low) : mask_q;
  assign pick_src = (state_q == S_CAPTURE) ? imp_vec : mask_nxt;

  always_comb begin
    pick_cid = '0;
    pick_lvl = '0;
    for (int k = NUM_C - 1; k >= 0; k--) begin
      if (pick_src[k]) begin
        pick_cid = WIDTH_CID'(k);
        pick_lvl = lvl_q[k*WIDTH_LVL +: WIDTH_LVL];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_ARB;
      S_ARB:     if (conflict_q || (mask_nxt == '0)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    mask_d      = mask_q;
    csat_drv_d  = csat_drv_q;
    imp_valid_d = 1'b0;
    imp_cid_d   = '0;
    imp_lvl_d   = '0;
    conflict_d  = conflict_q;
    conf_cid_d  = conf_cid_q;
    conf_lvl_d  = conf_lvl_q;
    done_d      = 1'b0;
    all_sat_d   = 1'b0;
    case (state_q)
      S_CAPTURE: begin
        mask_d     = imp_vec;
        csat_drv_d = csat_q;
        conflict_d = |conf_vec;
        conf_cid_d = conf_cid;
        conf_lvl_d = conf_lvl;
        // a conflict suppresses every implication of the round
        if (conf_vec == '0) begin
          imp_valid_d = |imp_vec;
          imp_cid_d   = pick_cid;
          imp_lvl_d   = pick_lvl;
        end
      end
      S_ARB: begin
        if (!conflict_q) begin
          mask_d      = mask_nxt;
          imp_valid_d = |mask_nxt;
          imp_cid_d   = pick_cid;
          imp_lvl_d   = pick_lvl;
        end
        if (state_d == S_DONE) begin
          done_d    = 1'b1;
          all_sat_d = all_sat_vec;
        end
      end
      S_DONE: begin
        mask_d     = '0;
        conflict_d = 1'b0;
        conf_cid_d = '0;
        conf_lvl_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csat_q      <= '0;
      cc_q        <= '0;
      alf_q       <= '0;
      flc_q       <= '0;
      len_q       <= '0;
      lvl_q       <= '0;
      mask_q      <= '0;
      csat_drv_q  <= '0;
      imp_valid_q <= 1'b0;
      imp_cid_q   <= '0;
      imp_lvl_q   <= '0;
      conflict_q  <= 1'b0;
      conf_cid_q  <= '0;
      conf_lvl_q  <= '0;
      done_q      <= 1'b0;
      all_sat_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start_i) begin
        csat_q <= csat_i;
        cc_q   <= conflict_c_i;
        alf_q  <= all_lit_false_i;
        flc_q  <= freelitcnt_i;
        len_q  <= clause_len_i;
        lvl_q  <= cmax_lvl_i;
      end
      mask_q      <= mask_d;
      csat_drv_q  <= csat_drv_d;
      imp_valid_q <= imp_valid_d;
      imp_cid_q   <= imp_cid_d;
      imp_lvl_q   <= imp_lvl_d;
      conflict_q  <= conflict_d;
      conf_cid_q  <= conf_cid_d;
      conf_lvl_q  <= conf_lvl_d;
      done_q      <= done_d;
      all_sat_q   <= all_sat_d;
    end
  end

  assign csat_drv_o     = csat_drv_q;
  assign imp_valid_o    = imp_valid_q;
  assign imp_cid_o      = imp_cid_q;
  assign imp_lvl_o      = imp_lvl_q;
  assign conflict_o     = conflict_q;
  assign conflict_cid_o = conf_cid_q;
  assign conflict_lvl_o = conf_lvl_q;
  assign done_o         = done_q;
  assign all_sat_o      = all_sat_q;
  assign busy_o         = (state_q != S_IDLE);

`ifdef TERMINAL_CELL_BANK_STATS_EN
  logic [15:0] imp_cnt_q, conf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      imp_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (hs && (imp_cnt_q != 16'hFFFF))
        imp_cnt_q <= imp_cnt_q + 16'd1;
      // counted on the CAPTURE->ARB transition, i.e. once per conflict round
      if ((state_q == S_CAPTURE) && (conf_vec != '0) && (conf_cnt_q != 16'hFFFF))
        conf_cnt_q <= conf_cnt_q + 16'd1;
    end
  end

  assign stat_imp_cnt_o  = imp_cnt_q;
  assign stat_conf_cnt_o = conf_cnt_q;
`else
  assign stat_imp_cnt_o  = 16'd0;
  assign stat_conf_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_terminal_cell_bank.sv
`timescale 1ns/1ps
module tb_terminal_cell_bank;
  localparam int NUM_C = 8;
  localparam int WL    = 16;
  localparam int WLEN  = 4;
  localparam int WCID  = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic                  imp_ready_i = 1'b0;
  logic [NUM_C-1:0]      csat_i = '0;
  logic [2*NUM_C-1:0]    freelitcnt_i = '0;
  logic [WLEN*NUM_C-1:0] clause_len_i = '0;
  logic [NUM_C-1:0]      conflict_c_i = '0;
  logic [NUM_C-1:0]      all_lit_false_i = '0;
  logic [WL*NUM_C-1:0]   cmax_lvl_i = '0;
  logic [NUM_C-1:0]      csat_drv_o;
  logic                  imp_valid_o;
  logic [WCID-1:0]       imp_cid_o;
  logic [WL-1:0]         imp_lvl_o;
  logic                  conflict_o;
  logic [WCID-1:0]       conflict_cid_o;
  logic [WL-1:0]         conflict_lvl_o;
  logic                  done_o;
  logic                  all_sat_o;
  logic                  busy_o;
  logic [15:0]           stat_imp_cnt_o;
  logic [15:0]           stat_conf_cnt_o;

  always #5 clk = ~clk;

  terminal_cell_bank #(
    .NUM_C(NUM_C), .WIDTH_LVL(WL), .WIDTH_C_LEN(WLEN), .WIDTH_CID(WCID)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .csat_i(csat_i), .freelitcnt_i(freelitcnt_i), .clause_len_i(clause_len_i),
    .conflict_c_i(conflict_c_i), .all_lit_false_i(all_lit_false_i),
    .cmax_lvl_i(cmax_lvl_i), .csat_drv_o(csat_drv_o),
    .imp_valid_o(imp_valid_o), .imp_ready_i(imp_ready_i),
    .imp_cid_o(imp_cid_o), .imp_lvl_o(imp_lvl_o),
    .conflict_o(conflict_o), .conflict_cid_o(conflict_cid_o),
    .conflict_lvl_o(conflict_lvl_o), .done_o(done_o), .all_sat_o(all_sat_o),
    .busy_o(busy_o), .stat_imp_cnt_o(stat_imp_cnt_o),
    .stat_conf_cnt_o(stat_conf_cnt_o)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Round outcome is computed once from the inputs seen with start_i:
  // the conflict summary, the ordered list of implying clauses and the
  // all-satisfied flag. m_stage is the cycle position within the round
  // (0 idle, 1 first cycle after start, 2 resolving, 3 completion cycle).
  int               m_stage    = 0;
  bit               m_conf     = 1'b0;
  int               m_conf_cid = 0;
  int               m_conf_lvl = 0;
  bit               m_all_sat  = 1'b0;
  int               q_cid[$];
  int               q_lvl[$];
  logic [NUM_C-1:0] m_csat_snap = '0;
  logic [NUM_C-1:0] m_csat_drv  = '0;
  int               m_imp_cnt   = 0;
  int               m_conf_cnt  = 0;

  function automatic int stat_inc(input int v);
`ifdef TERMINAL_CELL_BANK_STATS_EN
    return (v < 65535) ? v + 1 : v;
`else
    return 0;
`endif
  endfunction

  task automatic eval_round();
    m_conf = 1'b0; m_conf_cid = 0; m_conf_lvl = 0; m_all_sat = 1'b1;
    q_cid.delete(); q_lvl.delete();
    m_csat_snap = csat_i;
    for (int k = 0; k < NUM_C; k++) begin
      int len = int'(clause_len_i[k*WLEN +: WLEN]);
      int lvl = int'(cmax_lvl_i[k*WL +: WL]);
      int flc = int'(freelitcnt_i[2*k +: 2]);
      bit nonempty = (len != 0);
      if (conflict_c_i[k] || (all_lit_false_i[k] && nonempty)) begin
        if (!m_conf) m_conf_cid = k;
        m_conf = 1'b1;
        if (lvl > m_conf_lvl) m_conf_lvl = lvl;
      end
      if (nonempty && !csat_i[k] && flc == 1) begin
        q_cid.push_back(k);
        q_lvl.push_back(lvl);
      end
      if (nonempty && !csat_i[k]) m_all_sat = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_stage = 0; m_conf = 1'b0; m_conf_cid = 0; m_conf_lvl = 0;
      q_cid.delete(); q_lvl.delete();
      m_csat_drv = '0; m_imp_cnt = 0; m_conf_cnt = 0;
    end else begin
      case (m_stage)
        0: if (start_i) begin eval_round(); m_stage = 1; end
        1: begin
          m_csat_drv = m_csat_snap;
          if (m_conf) m_conf_cnt = stat_inc(m_conf_cnt);
          m_stage = 2;
        end
        2: begin
          if (m_conf) m_stage = 3;
          else begin
            if (q_cid.size() > 0 && imp_ready_i) begin
              void'(q_cid.pop_front());
              void'(q_lvl.pop_front());
              m_imp_cnt = stat_inc(m_imp_cnt);
            end
            if (q_cid.size() == 0) m_stage = 3;
          end
        end
        default: begin m_stage = 0; m_conf = 1'b0; end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_valid;
  bit e_conf;
  always @(negedge clk) begin
    if (chk_en) begin
      e_conf  = (m_stage >= 2) && m_conf;
      e_valid = (m_stage == 2) && !m_conf && (q_cid.size() > 0);
      cmp("busy", 32'(busy_o), 32'(m_stage != 0));
      cmp("conflict", 32'(conflict_o), 32'(e_conf));
      cmp("conflict_cid", 32'(conflict_cid_o), e_conf ? m_conf_cid : 0);
      cmp("conflict_lvl", 32'(conflict_lvl_o), e_conf ? m_conf_lvl : 0);
      cmp("imp_valid", 32'(imp_valid_o), 32'(e_valid));
      if (e_valid) begin
        cmp("imp_cid", 32'(imp_cid_o), q_cid[0]);
        cmp("imp_lvl", 32'(imp_lvl_o), q_lvl[0]);
      end
      cmp("done", 32'(done_o), 32'(m_stage == 3));
      if (m_stage == 3) cmp("all_sat", 32'(all_sat_o), 32'(m_all_sat));
      cmp("csat_drv", 32'(csat_drv_o), 32'(m_csat_drv));
      cmp("stat_imp", 32'(stat_imp_cnt_o), m_imp_cnt);
      cmp("stat_conf", 32'(stat_conf_cnt_o), m_conf_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_rows();
    csat_i = '0; freelitcnt_i = '0; clause_len_i = '0;
    conflict_c_i = '0; all_lit_false_i = '0; cmax_lvl_i = '0;
  endtask

  task automatic set_row(input int k, input bit sat, input logic [1:0] flc,
                         input logic [3:0] len, input bit cc, input bit alf,
                         input logic [15:0] lvl);
    csat_i[k]                = sat;
    freelitcnt_i[2*k +: 2]   = flc;
    clause_len_i[k*WLEN +: WLEN] = len;
    conflict_c_i[k]          = cc;
    all_lit_false_i[k]       = alf;
    cmax_lvl_i[k*WL +: WL]   = lvl;
  endtask

  task automatic two_imp_rows();
    clear_rows();
    set_row(2, 1'b0, 2'b01, 4'd3, 1'b0, 1'b0, 16'd7);
    set_row(5, 1'b0, 2'b01, 4'd3, 1'b0, 1'b0, 16'd9);
    set_row(0, 1'b0, 2'b11, 4'd3, 1'b0, 1'b0, 16'd20); // 3+ free: not implying
    set_row(1, 1'b1, 2'b01, 4'd3, 1'b0, 1'b0, 16'd30); // satisfied
    set_row(7, 1'b0, 2'b01, 4'd0, 1'b0, 1'b1, 16'd40); // empty row
  endtask

  // leaves the bench one cycle after the start edge (cycle 1)
  task automatic start_round();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      if (done_o) return;
      step();
      cyc++;
    end
    n_vec++;
    n_miss++;
    $display("FAIL wait_done: no done_o within 40 cycles (t=%0t)", $time);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    cmp("reset_busy", 32'(busy_o), 0);
    cmp("reset_csat_drv", 32'(csat_drv_o), 0);

    // all rows empty
    clear_rows();
    start_round();
    wait_done(cyc);
    cmp("empty_done_cycle", cyc, 3);
    cmp("empty_all_sat", 32'(all_sat_o), 1);
    step();

    // two implications, ready held high
    two_imp_rows();
    imp_ready_i = 1'b1;
    start_round();
    cmp("model_imp_count", q_cid.size(), 2);
    step();
    cmp("imp0_valid", 32'(imp_valid_o), 1);
    cmp("imp0_cid", 32'(imp_cid_o), 2);
    cmp("imp0_lvl", 32'(imp_lvl_o), 7);
    cmp("csat_drv_snap", 32'(csat_drv_o), 32'h02);
    step();
    cmp("imp1_cid", 32'(imp_cid_o), 5);
    cmp("imp1_lvl", 32'(imp_lvl_o), 9);
    step();
    cmp("imp_done", 32'(done_o), 1);
    cmp("imp_all_sat", 32'(all_sat_o), 0);
    step();

    // backpressure: ready low for 4 cycles
    imp_ready_i = 1'b0;
    start_round();
    step();
    for (int i = 0; i < 4; i++) begin
      cmp("stall_valid", 32'(imp_valid_o), 1);
      cmp("stall_cid", 32'(imp_cid_o), 2);
      step();
    end
    imp_ready_i = 1'b1;
    step();
    cmp("stall_next_cid", 32'(imp_cid_o), 5);
    step();
    cmp("stall_done", 32'(done_o), 1);
    step();

    // conflict beats implication
    clear_rows();
    set_row(6, 1'b0, 2'b00, 4'd2, 1'b0, 1'b1, 16'd4);
    set_row(3, 1'b0, 2'b10, 4'd3, 1'b1, 1'b0, 16'd11);
    set_row(1, 1'b0, 2'b01, 4'd3, 1'b0, 1'b0, 16'd2);
    start_round();
    cmp("model_conf_lvl", m_conf_lvl, 11);
    step();
    cmp("conf_flag", 32'(conflict_o), 1);
    cmp("conf_cid", 32'(conflict_cid_o), 3);
    cmp("conf_lvl", 32'(conflict_lvl_o), 11);
    cmp("conf_no_imp", 32'(imp_valid_o), 0);
    step();
    cmp("conf_done", 32'(done_o), 1);
    cmp("conf_hold", 32'(conflict_o), 1);
    step();
    cmp("conf_clear", 32'(conflict_o), 0);

    // level tie, empty-row all_lit_false ignored
    clear_rows();
    set_row(4, 1'b0, 2'b00, 4'd3, 1'b0, 1'b1, 16'd6);
    set_row(1, 1'b0, 2'b00, 4'd2, 1'b1, 1'b0, 16'd6);
    set_row(7, 1'b0, 2'b00, 4'd2, 1'b1, 1'b0, 16'd3);
    set_row(5, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 16'd50);
    start_round();
    step();
    cmp("tie_cid", 32'(conflict_cid_o), 1);
    cmp("tie_lvl", 32'(conflict_lvl_o), 6);
    step();
    step();

    // reset mid-round with two implications pending
    two_imp_rows();
    imp_ready_i = 1'b0;
    start_round();
    step();
    step();
    rst = 1'b1;
    step();
    cmp("rst_busy", 32'(busy_o), 0);
    cmp("rst_valid", 32'(imp_valid_o), 0);
    cmp("rst_done", 32'(done_o), 0);
    cmp("rst_csat_drv", 32'(csat_drv_o), 0);
    rst = 1'b0;
    imp_ready_i = 1'b1;
    start_round();
    wait_done(cyc);
    cmp("rerun_done_cycle", cyc, 4);
    step();

    // one implication, then one conflict round
    clear_rows();
    set_row(4, 1'b0, 2'b01, 4'd5, 1'b0, 1'b0, 16'd13);
    start_round();
    wait_done(cyc);
    cmp("single_done_cycle", cyc, 3);
    step();
    clear_rows();
    set_row(2, 1'b0, 2'b00, 4'd1, 1'b0, 1'b1, 16'd8);
    start_round();
    wait_done(cyc);
    step();

`ifdef TERMINAL_CELL_BANK_STATS_EN
    cmp("stat_imp_final", 32'(stat_imp_cnt_o), 3);
    cmp("stat_conf_final", 32'(stat_conf_cnt_o), 1);
`else
    cmp("stat_imp_final", 32'(stat_imp_cnt_o), 0);
    cmp("stat_conf_final", 32'(stat_conf_cnt_o), 0);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
